// File: rtl/combi_sweep_pkg.sv
// Shared definitions for the combi_ckt truth-table sweep sequencer.
package combi_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int CNT_W       = 5;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times how long each vector is held.
module sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int          TW       = 4;
    localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/combi_sweep_ctrl.sv
// Sweeps combi_ckt through all 16 input vectors and checks the captured
// truth table against an expected table.
module combi_sweep_ctrl
    import combi_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    input  logic                   y,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] result,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic                   fail_valid,
    output logic [VEC_W-1:0]       first_fail,
    output logic                   pass
);

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

    sweep_state_t             state_q, state_d;
    logic [VEC_W-1:0]         idx_q, idx_d;
    logic [NUM_VECTORS-1:0]   exp_q, exp_d;
    logic [NUM_VECTORS-1:0]   result_q, result_d;
    logic [CNT_W-1:0]         mm_q, mm_d;
    logic                     fail_q, fail_d;
    logic [VEC_W-1:0]         ff_q, ff_d;
    logic                     pass_q, pass_d;
    logic                     tmr_load;
    logic                     tmr_dec;
    logic                     tmr_zero;

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        result_d = result_q;
        mm_d     = mm_q;
        fail_d   = fail_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    result_d = '0;
                    mm_d     = '0;
                    fail_d   = 1'b0;
                    ff_d     = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                result_d[idx_q] = y;
                if (y != exp_q[idx_q]) begin
                    mm_d = mm_q + 1'b1;
                    if (!fail_q) begin
                        ff_d   = idx_q;
                        fail_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // pass must reflect the final sample as well
                    pass_d  = !fail_d;
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            mm_q     <= '0;
            fail_q   <= 1'b0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            mm_q     <= mm_d;
            fail_q   <= fail_d;
            ff_q     <= ff_d;
            pass_q   <= pass_d;
        end
    end

    logic drive;
    assign drive = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

    assign {a, b, c, d}   = drive ? idx_q : '0;
    assign busy           = drive;
    assign done           = (state_q == ST_DONE);
    assign result         = result_q;
    assign mismatch_cnt   = mm_q;
    assign fail_valid     = fail_q;
    assign first_fail     = ff_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_combi_sweep_ctrl.sv
// Directed-vector bench for combi_sweep_ctrl with behavioural combi_ckt models.
module tb_combi_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] exp0 = '0;
    logic [15:0] exp1 = '0;

    logic        a0, b0, c0, d0, y0, busy0, done0, fail0, pass0;
    logic [15:0] res0;
    logic [4:0]  mm0;
    logic [3:0]  ff0;

    logic        a1, b1, c1, d1, y1, busy1, done1, fail1, pass1;
    logic [15:0] res1;
    logic [4:0]  mm1;
    logic [3:0]  ff1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y0 = a0 & b0;
    assign y1 = d1;

    combi_sweep_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0),
        .a(a0), .b(b0), .c(c0), .d(d0), .y(y0),
        .busy(busy0), .done(done0), .result(res0),
        .mismatch_cnt(mm0), .fail_valid(fail0),
        .first_fail(ff0), .pass(pass0)
    );

    combi_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1),
        .a(a1), .b(b1), .c(c1), .d(d1), .y(y1),
        .busy(busy1), .done(done1), .result(res1),
        .mismatch_cnt(mm1), .fail_valid(fail1),
        .first_fail(ff1), .pass(pass1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Accept a start on dut0, watch 55 cycles; k = cycles since accept edge.
    task automatic sweep0(input logic [15:0] ex, input int restart_k,
                          output int done_k, output int n_done);
        done_k = 0;
        n_done = 0;
        @(posedge clk); #1;
        exp0   = ex;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("busy_k0", 64'(busy0), 64'd1);
        check("vec_k0", 64'({a0, b0, c0, d0}), 64'd0);
        for (int k = 1; k <= 55; k++) begin
            @(posedge clk); #1;
            start0 = (k == restart_k);
            if (k == 3) check("vec_k3", 64'({a0, b0, c0, d0}), 64'd1);
            if (done0) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
        end
        start0 = 1'b0;
    endtask

    int dk, nd;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out0", 64'({busy0, done0, a0, b0, c0, d0, res0,
                               mm0, fail0, ff0, pass0}), 64'd0);
        check("rst_out1", 64'({busy1, done1, a1, b1, c1, d1, res1,
                               mm1, fail1, ff1, pass1}), 64'd0);
        repeat (10) @(posedge clk);
        #1 check("idle_busy", 64'(busy0), 64'd0);

        sweep0(16'hF000, 0, dk, nd);
        check("s1_done_cyc", 64'(dk), 64'd48);
        check("s1_done_n", 64'(nd), 64'd1);
        check("s1_result", 64'(res0), 64'hF000);
        check("s1_mm", 64'(mm0), 64'd0);
        check("s1_fail", 64'(fail0), 64'd0);
        check("s1_pass", 64'(pass0), 64'd1);

        sweep0(16'hF001, 0, dk, nd);
        check("s2_done_cyc", 64'(dk), 64'd48);
        check("s2_result", 64'(res0), 64'hF000);
        check("s2_mm", 64'(mm0), 64'd1);
        check("s2_fail", 64'(fail0), 64'd1);
        check("s2_ff", 64'(ff0), 64'd0);
        check("s2_pass", 64'(pass0), 64'd0);

        sweep0(16'hF001, 16, dk, nd);
        check("s3_done_cyc", 64'(dk), 64'd48);
        check("s3_done_n", 64'(nd), 64'd1);
        check("s3_result", 64'(res0), 64'hF000);
        check("s3_mm", 64'(mm0), 64'd1);
        check("s3_ff", 64'(ff0), 64'd0);
        check("s3_pass", 64'(pass0), 64'd0);

        @(posedge clk); #1;
        exp0   = 16'h0000;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (22) @(posedge clk);
        #1 check("s4_vec7", 64'({a0, b0, c0, d0}), 64'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("s4_rst_out", 64'({busy0, done0, a0, b0, c0, d0, res0,
                                 mm0, fail0, ff0, pass0}), 64'd0);
        sweep0(16'hF000, 0, dk, nd);
        check("s4_done_cyc", 64'(dk), 64'd48);
        check("s4_result", 64'(res0), 64'hF000);
        check("s4_pass", 64'(pass0), 64'd1);

        dk = 0;
        nd = 0;
        @(posedge clk); #1;
        exp1   = 16'h5555;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done1) begin
                nd++;
                if (dk == 0) dk = k;
            end
        end
        check("s5_done_cyc", 64'(dk), 64'd32);
        check("s5_done_n", 64'(nd), 64'd1);
        check("s5_result", 64'(res1), 64'hAAAA);
        check("s5_mm", 64'(mm1), 64'd16);
        check("s5_fail", 64'(fail1), 64'd1);
        check("s5_ff", 64'(ff1), 64'd0);
        check("s5_pass", 64'(pass1), 64'd0);
        check("s5_dut0_idle", 64'(busy0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
